// File: rtl/hci_source_job_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// hci_source_job_sequencer_pkg
// Shared types for the source-streamer job sequencer:
//   - hci_seq_state_t       : sequencer FSM states
//   - ctrl_addressgen_v3_t  : addressgen job descriptor (layout of the
//                             hwpe_stream_package type of the same name)
//   - hci_streamer_ctrl_t   : streamer ctrl_i bundle (req_start + descriptor)
//   - hci_streamer_flags_t  : streamer flags_o subset used by the sequencer
//   - HCI_SEQ_DEFAULT_DEPTH : default job queue depth
// -----------------------------------------------------------------------------
package hci_source_job_sequencer_pkg;

   localparam int unsigned HCI_SEQ_DEFAULT_DEPTH = 4;

   typedef enum logic {
      SEQ_IDLE,
      SEQ_RUN
   } hci_seq_state_t;

   typedef struct packed {
      logic [31:0] base_addr;
      logic [31:0] tot_len;
      logic [31:0] d0_len;
      logic [31:0] d0_stride;
      logic [31:0] d1_len;
      logic [31:0] d1_stride;
      logic [31:0] d2_stride;
      logic [1:0]  dim_enable_1h;
   } ctrl_addressgen_v3_t;

   typedef struct packed {
      logic                req_start;
      ctrl_addressgen_v3_t addressgen_ctrl;
   } hci_streamer_ctrl_t;

   typedef struct packed {
      logic ready_start;
      logic done;
   } hci_streamer_flags_t;

endpackage

// File: rtl/hci_source_job_sequencer_queue.sv
// -----------------------------------------------------------------------------
// hci_source_job_queue
// Circular buffer of JOB_DEPTH job descriptors. Pointers carry one extra wrap
// bit so full and empty are distinguishable without a separate counter.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   clear_i         sync clear (empties the queue, wins over push/pop)
//   push_i, data_i  push request and descriptor (ignored while full)
//   pop_i           pop request (ignored while empty)
//   data_o          head descriptor (valid when !empty_o)
//   full_o, empty_o occupancy flags
// -----------------------------------------------------------------------------
module hci_source_job_queue
   import hci_source_job_sequencer_pkg::*;
#(
   parameter int unsigned JOB_DEPTH = HCI_SEQ_DEFAULT_DEPTH
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                clear_i,
   input  logic                push_i,
   input  ctrl_addressgen_v3_t data_i,
   input  logic                pop_i,
   output ctrl_addressgen_v3_t data_o,
   output logic                full_o,
   output logic                empty_o
);

   localparam int unsigned PtrW = $clog2(JOB_DEPTH);

   ctrl_addressgen_v3_t mem_q [JOB_DEPTH];
   logic [PtrW:0]       wr_ptr_q, wr_ptr_d;
   logic [PtrW:0]       rd_ptr_q, rd_ptr_d;
   logic                push_en, pop_en;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                    (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

   // Full is judged before any same-cycle pop, so a full queue never accepts.
   assign push_en = push_i && !full_o;
   assign pop_en  = pop_i && !empty_o;

   assign data_o = mem_q[rd_ptr_q[PtrW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push_en) wr_ptr_d = wr_ptr_q + (PtrW+1)'(1);
         if (pop_en)  rd_ptr_d = rd_ptr_q + (PtrW+1)'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: the head is masked by empty_o downstream.
   always_ff @(posedge clk_i) begin
      if (push_en && !clear_i) mem_q[wr_ptr_q[PtrW-1:0]] <= data_i;
   end

endmodule

// File: rtl/hci_source_job_sequencer.sv
// -----------------------------------------------------------------------------
// hci_source_job_sequencer
// Queues addressgen jobs for one TCDM source streamer, issues one req_start
// per job, holds the descriptor until done, counts completions.
// Optional watchdog: define HCI_SOURCE_SEQ_TIMEOUT_EN to abort jobs that run
// TIMEOUT_CYCLES cycles without done (streamer_clear_o pulse, sticky err_o).
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   clear_i              sync clear of FSM, queue, counter, error
//   enable_i             FSM advance enable
//   job_valid_i/_ready_o job push handshake, job_i descriptor
//   ctrl_o / flags_i     streamer ctrl/flags handshake
//   busy_o               FSM not idle or jobs queued
//   evt_done_o           1-cycle pulse per completed job
//   jobs_done_o          completed-job count (wraps)
//   streamer_clear_o     1-cycle streamer clear on watchdog abort
//   err_o                sticky watchdog error
// -----------------------------------------------------------------------------
module hci_source_job_sequencer
   import hci_source_job_sequencer_pkg::*;
#(
   parameter int unsigned JOB_DEPTH      = HCI_SEQ_DEFAULT_DEPTH,
   parameter int unsigned CNT_WIDTH      = 16,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear_i,
   input  logic                 enable_i,
   input  logic                 job_valid_i,
   output logic                 job_ready_o,
   input  ctrl_addressgen_v3_t  job_i,
   output hci_streamer_ctrl_t   ctrl_o,
   input  hci_streamer_flags_t  flags_i,
   output logic                 busy_o,
   output logic                 evt_done_o,
   output logic [CNT_WIDTH-1:0] jobs_done_o,
   output logic                 streamer_clear_o,
   output logic                 err_o
);

   if (JOB_DEPTH < 2 || (JOB_DEPTH & (JOB_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("JOB_DEPTH must be a power of two >= 2");
   end
   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be >= 1");
   end

   hci_seq_state_t      state_q, state_d;
   ctrl_addressgen_v3_t q_head;
   logic                q_full, q_empty;
   logic                q_pop;
   logic                req_start;
   logic                evt_done;
   logic                tmo_abort;
   logic                timeout;
   logic [CNT_WIDTH-1:0] jobs_done_q;

   hci_source_job_queue #(
      .JOB_DEPTH (JOB_DEPTH)
   ) i_queue (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .push_i  (job_valid_i),
      .data_i  (job_i),
      .pop_i   (q_pop),
      .data_o  (q_head),
      .full_o  (q_full),
      .empty_o (q_empty)
   );

   assign job_ready_o = !q_full;
   assign busy_o      = (state_q != SEQ_IDLE) || !q_empty;
   assign evt_done_o  = evt_done;
   assign jobs_done_o = jobs_done_q;

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= SEQ_IDLE;
      else         state_q <= state_d;
   end

   // Next state. A done seen in RUN always ends the job, even with enable_i
   // low, so completions are never lost; enable_i only gates job starts.
   always_comb begin
      state_d = state_q;
      case (state_q)
         SEQ_IDLE: if (enable_i && !q_empty && flags_i.ready_start) state_d = SEQ_RUN;
         SEQ_RUN:  if (flags_i.done || timeout) state_d = SEQ_IDLE;
         default:  state_d = SEQ_IDLE;
      endcase
      if (clear_i) state_d = SEQ_IDLE;
   end

   // Outputs; clear_i suppresses every event in its cycle.
   always_comb begin
      req_start = 1'b0;
      evt_done  = 1'b0;
      tmo_abort = 1'b0;
      if (!clear_i) begin
         case (state_q)
            SEQ_IDLE: req_start = enable_i && !q_empty && flags_i.ready_start;
            SEQ_RUN: begin
               evt_done  = flags_i.done;
               tmo_abort = !flags_i.done && timeout;
            end
            default: ;
         endcase
      end
      q_pop                  = evt_done || tmo_abort;
      ctrl_o.req_start       = req_start;
      ctrl_o.addressgen_ctrl = q_empty ? '0 : q_head;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)       jobs_done_q <= '0;
      else if (clear_i)  jobs_done_q <= '0;
      else if (evt_done) jobs_done_q <= jobs_done_q + CNT_WIDTH'(1);
   end

`ifdef HCI_SOURCE_SEQ_TIMEOUT_EN
   localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

   // run_cnt_q holds the number of RUN cycles already elapsed, so the abort
   // fires in RUN cycle TIMEOUT_CYCLES.
   logic [TmoW-1:0] run_cnt_q;
   logic            err_q;

   assign timeout          = (state_q == SEQ_RUN) && (run_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));
   assign streamer_clear_o = tmo_abort;
   assign err_o            = err_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         run_cnt_q <= '0;
         err_q     <= 1'b0;
      end else if (clear_i) begin
         run_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         if (req_start)               run_cnt_q <= '0;
         else if (state_q == SEQ_RUN) run_cnt_q <= run_cnt_q + TmoW'(1);
         if (tmo_abort) err_q <= 1'b1;
      end
   end
`else
   assign timeout          = 1'b0;
   assign streamer_clear_o = 1'b0;
   assign err_o            = 1'b0;
`endif

endmodule

// File: tb/tb_hci_source_job_sequencer.sv
module tb_hci_source_job_sequencer;
   import hci_source_job_sequencer_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned TMO   = 16;
`ifdef HCI_SOURCE_SEQ_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic                clk_i = 1'b0;
   logic                rst_ni;
   logic                clear_i;
   logic                enable_i;
   logic                job_valid_i;
   logic                job_ready_o;
   ctrl_addressgen_v3_t job_i;
   hci_streamer_ctrl_t  ctrl_o;
   hci_streamer_flags_t flags_i;
   logic                busy_o;
   logic                evt_done_o;
   logic [CNT_W-1:0]    jobs_done_o;
   logic                streamer_clear_o;
   logic                err_o;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Reference model: a plain FIFO of pending jobs, whether its head is
   // currently running, and how long it has been running.
   ctrl_addressgen_v3_t mq[$];
   bit                  m_active = 1'b0;
   int unsigned         m_run    = 0;
   int unsigned         m_cnt    = 0;
   bit                  m_err    = 1'b0;

   always #5 clk_i = ~clk_i;

   hci_source_job_sequencer #(
      .JOB_DEPTH      (DEPTH),
      .CNT_WIDTH      (CNT_W),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .clear_i          (clear_i),
      .enable_i         (enable_i),
      .job_valid_i      (job_valid_i),
      .job_ready_o      (job_ready_o),
      .job_i            (job_i),
      .ctrl_o           (ctrl_o),
      .flags_i          (flags_i),
      .busy_o           (busy_o),
      .evt_done_o       (evt_done_o),
      .jobs_done_o      (jobs_done_o),
      .streamer_clear_o (streamer_clear_o),
      .err_o            (err_o)
   );

   task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   function automatic ctrl_addressgen_v3_t rjob(input int unsigned len);
      ctrl_addressgen_v3_t j;
      j.base_addr     = $urandom;
      j.tot_len       = len;
      j.d0_len        = $urandom;
      j.d0_stride     = $urandom;
      j.d1_len        = $urandom;
      j.d1_stride     = $urandom;
      j.d2_stride     = $urandom;
      j.dim_enable_1h = 2'($urandom_range(0, 3));
      return j;
   endfunction

   // One clock cycle: drive inputs, check all outputs against the model,
   // then advance the model across the rising edge. Entered at a negedge.
   task automatic step(input bit v, input ctrl_addressgen_v3_t j, input bit en,
                       input bit rs, input bit dn, input bit clr);
      int unsigned         sz;
      bit                  e_ready, e_req, e_evt, e_tmo, e_busy;
      ctrl_addressgen_v3_t e_head;
      job_valid_i         = v;
      job_i               = j;
      enable_i            = en;
      flags_i.ready_start = rs;
      flags_i.done        = dn;
      clear_i             = clr;
      #1;
      sz      = mq.size();
      e_ready = (sz < DEPTH);
      e_head  = (sz != 0) ? mq[0] : '0;
      e_req   = !clr && !m_active && en && rs && (sz != 0);
      e_evt   = !clr && m_active && dn;
      e_tmo   = TMO_EN && !clr && m_active && !dn && (m_run == TMO - 1);
      e_busy  = m_active || (sz != 0);
      check("job_ready", 256'(job_ready_o), 256'(e_ready));
      check("req_start", 256'(ctrl_o.req_start), 256'(e_req));
      check("addrgen_ctrl", 256'(ctrl_o.addressgen_ctrl), 256'(e_head));
      check("busy", 256'(busy_o), 256'(e_busy));
      check("evt_done", 256'(evt_done_o), 256'(e_evt));
      check("jobs_done", 256'(jobs_done_o), 256'(m_cnt));
      check("streamer_clear", 256'(streamer_clear_o), 256'(e_tmo));
      check("err", 256'(err_o), 256'(m_err));
      @(posedge clk_i);
      if (clr) begin
         mq.delete();
         m_active = 1'b0;
         m_run    = 0;
         m_cnt    = 0;
         m_err    = 1'b0;
      end else begin
         if (e_evt || e_tmo) begin
            mq.delete(0);
            m_active = 1'b0;
         end
         if (e_evt) m_cnt = (m_cnt + 1) % (1 << CNT_W);
         if (e_tmo) m_err = 1'b1;
         if (e_req) begin
            m_active = 1'b1;
            m_run    = 0;
         end else if (m_active) begin
            m_run++;
         end
         if (v && e_ready) mq.push_back(j);
      end
      @(negedge clk_i);
   endtask

   task automatic idle(input int unsigned n, input bit rs);
      for (int i = 0; i < int'(n); i++) step(0, rjob(0), 1, rs, 0, 0);
   endtask

   initial begin
      ctrl_addressgen_v3_t zj;
      zj          = '0;
      rst_ni      = 1'b0;
      clear_i     = 1'b0;
      enable_i    = 1'b0;
      job_valid_i = 1'b0;
      job_i       = '0;
      flags_i     = '0;
      repeat (2) @(negedge clk_i);
      // Reset state
      check("rst_job_ready", 256'(job_ready_o), 256'(1));
      check("rst_req_start", 256'(ctrl_o.req_start), 256'(0));
      check("rst_addrgen", 256'(ctrl_o.addressgen_ctrl), 256'(0));
      check("rst_busy", 256'(busy_o), 256'(0));
      check("rst_jobs_done", 256'(jobs_done_o), 256'(0));
      check("rst_err", 256'(err_o), 256'(0));
      rst_ni = 1'b1;
      idle(2, 1);

      // Single job, done held off for 20 cycles
      step(1, rjob(8), 1, 1, 0, 0);
      idle(21, 1);
      step(0, zj, 1, 1, 1, 0);
      idle(2, 1);

      // Fill the queue with starts blocked, then attempt a fifth push
      for (int i = 0; i < 4; i++) step(1, rjob(i + 1), 1, 0, 0, 0);
      step(1, rjob(99), 1, 0, 0, 0);
      // Drain back-to-back; push attempts during the full-queue done are refused
      for (int i = 0; i < 4; i++) begin
         step(1, rjob(50 + i), 1, 1, 0, 0);
         step(1, rjob(60 + i), 1, 1, 1, 0);
      end
      idle(10, 1);
      for (int i = 0; i < 8; i++) step(0, zj, 1, 1, 1, 0);
      idle(2, 1);

      // Clear while running with 3 jobs queued
      for (int i = 0; i < 3; i++) step(1, rjob(i + 10), 1, 0, 0, 0);
      step(0, zj, 1, 1, 0, 0);
      step(0, zj, 1, 1, 0, 0);
      step(0, zj, 1, 1, 0, 1);
      idle(2, 1);

      // enable_i low blocks the start; raising it starts in the same cycle
      step(1, rjob(5), 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) step(0, zj, 0, 1, 0, 0);
      step(0, zj, 1, 1, 0, 0);
      // done while enable_i is low is still taken
      step(0, zj, 0, 1, 1, 0);
      idle(2, 1);

      // Job that never completes, with another queued behind it
      step(1, rjob(7), 1, 0, 0, 0);
      step(1, rjob(9), 1, 0, 0, 0);
      for (int i = 0; i < int'(TMO) + 4; i++) step(0, zj, 1, 1, 0, 0);
      for (int i = 0; i < int'(TMO) + 4; i++) step(0, zj, 1, 1, 0, 0);
      step(0, zj, 1, 1, 0, 1);
      idle(2, 1);

      // Randomized traffic (counter wraps at 2^CNT_W)
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 2) != 0), rjob($urandom_range(1, 64)),
              ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 4) == 0), ($urandom_range(0, 199) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
